audio_fader: RTL and testbench



---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_fader_sample_scaler.sv | 30 +++
 rtl/audio_fader.sv | 171 +++++++++++++++++
 tb/tb_audio_fader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the song-end fader.
package audio_pkg;

    localparam int unsigned GAIN_W = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StFade,
        StDone
    } fader_state_e;

    // Samples per gain step: fade_ms / 8, never less than one, so that
    // 256 steps last about fade_ms at 32 kHz.
    function automatic logic [12:0] fade_period(input logic [15:0] fade_ms);
        logic [12:0] p;
        p = fade_ms[15:3];
        return (p == 13'd0) ? 13'd1 : p;
    endfunction

endpackage

// File: rtl/audio_fader_sample_scaler.sv
// sample_scaler: one audio channel scaled by an unsigned 0..256 gain.
// Registered, one cycle of latency; the output holds between strobes.
module sample_scaler
    import audio_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [15:0]       sample,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [15:0]       scaled
);

    logic signed [GAIN_W:0]      gain_s;
    logic signed [16+GAIN_W:0]   product;

    // Gain is zero-extended so 256 multiplies as +256, not -256.
    assign gain_s  = signed'({1'b0, gain});
    assign product = sample * gain_s;

    // Capture the scaled sample on each strobe; arithmetic shift floors negatives.
    always_ff @(posedge clk) begin
        if (reset) begin
            scaled <= 16'sd0;
        end else if (en) begin
            scaled <= 16'(product >>> 8);
        end
    end

endmodule

// File: rtl/audio_fader.sv
// audio_fader: counts played samples, fades gain to zero at song length and
// mutes output outside a playing song.
// Optional feature macro: AUDIO_FADER_SOFTSTART_EN (gain ramps 0->256 on entry
// to PLAY instead of jumping straight to unity).
module audio_fader
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = 32000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic        [15:0]       length_s,
    input  logic        [15:0]       fade_ms,
    input  logic                     in_rdy,
    input  logic signed [15:0]       in_l,
    input  logic signed [15:0]       in_r,
    output logic                     out_rdy,
    output logic signed [15:0]       out_l,
    output logic signed [15:0]       out_r,
    output logic        [GAIN_W-1:0] gain,
    output logic                     fading,
    output logic                     done
);

    localparam int unsigned SMP_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_RATE - 1);

    fader_state_e       state_q;
    logic [SMP_W-1:0]   smp_cnt_q;
    logic [15:0]        sec_cnt_q;
    logic [12:0]        step_cnt_q;
    logic [15:0]        len_q;
    logic [15:0]        fade_q;
    logic [GAIN_W-1:0]  gain_q;
    logic               fading_q;
    logic               done_q;
    logic               out_rdy_q;

    logic               smp_wrap;
    logic [15:0]        sec_next;
    logic               len_hit;
    logic [12:0]        step_period;
    logic               step_hit;
    logic [GAIN_W-1:0]  scale_gain;
    logic [GAIN_W-1:0]  start_gain;
    logic [GAIN_W-1:0]  play_gain;

    // Song-clock decode and the gain applied to the sample arriving this cycle.
    always_comb begin
        smp_wrap    = (smp_cnt_q == SMP_LAST);
        sec_next    = (sec_cnt_q == 16'hFFFF) ? sec_cnt_q : sec_cnt_q + 16'd1;
        // Trigger only when the seconds count actually steps onto length_s.
        len_hit     = smp_wrap && (sec_cnt_q != 16'hFFFF) && (sec_next == len_q) &&
                      (len_q != 16'd0);
        step_period = fade_period(fade_q);
        step_hit    = (step_cnt_q == step_period - 13'd1);
        // A sample coinciding with start or abort is muted.
        scale_gain  = (start || abort) ? '0 : gain_q;
`ifdef AUDIO_FADER_SOFTSTART_EN
        start_gain  = '0;
        play_gain   = (gain_q < GAIN_UNITY) ? gain_q + 9'd1 : gain_q;
`else
        start_gain  = GAIN_UNITY;
        play_gain   = gain_q;
`endif
    end

    // Player FSM with song counters and registered gain/fading/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            smp_cnt_q  <= '0;
            sec_cnt_q  <= 16'd0;
            step_cnt_q <= 13'd0;
            len_q      <= 16'd0;
            fade_q     <= 16'd0;
            gain_q     <= '0;
            fading_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q    <= StPlay;
                smp_cnt_q  <= '0;
                sec_cnt_q  <= 16'd0;
                step_cnt_q <= 13'd0;
                len_q      <= length_s;
                fade_q     <= fade_ms;
                gain_q     <= start_gain;
                fading_q   <= 1'b0;
            end else if (abort) begin
                state_q  <= StIdle;
                gain_q   <= '0;
                fading_q <= 1'b0;
            end else if (in_rdy) begin
                unique case (state_q)
                    StPlay: begin
                        smp_cnt_q <= smp_wrap ? '0 : smp_cnt_q + 1'b1;
                        if (smp_wrap) begin
                            sec_cnt_q <= sec_next;
                        end
                        if (len_hit) begin
                            if ((fade_q == 16'd0) || (gain_q == '0)) begin
                                state_q <= StDone;
                                gain_q  <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                // Fade starts from whatever gain is current.
                                state_q    <= StFade;
                                fading_q   <= 1'b1;
                                step_cnt_q <= 13'd0;
                            end
                        end else begin
                            gain_q <= play_gain;
                        end
                    end
                    StFade: begin
                        if (step_hit) begin
                            step_cnt_q <= 13'd0;
                            gain_q     <= gain_q - 9'd1;
                            if (gain_q == 9'd1) begin
                                state_q  <= StDone;
                                fading_q <= 1'b0;
                                done_q   <= 1'b1;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + 13'd1;
                        end
                    end
                    StIdle: ;
                    StDone: ;
                endcase
            end
        end
    end

    // Output strobe trails the input strobe by the scaler latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_rdy_q <= 1'b0;
        end else begin
            out_rdy_q <= in_rdy;
        end
    end

    sample_scaler u_scale_l (
        .clk    (clk),
        .reset  (reset),
        .en     (in_rdy),
        .sample (in_l),
        .gain   (scale_gain),
        .scaled (out_l)
    );

    sample_scaler u_scale_r (
        .clk    (clk),
        .reset  (reset),
        .en     (in_rdy),
        .sample (in_r),
        .gain   (scale_gain),
        .scaled (out_r)
    );

    assign out_rdy = out_rdy_q;
    assign gain    = gain_q;
    assign fading  = fading_q;
    assign done    = done_q;

endmodule

// File: tb/tb_audio_fader.sv
// Directed bench for audio_fader with SAMPLE_RATE = 100.
module tb_audio_fader;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [15:0]        length_s;
    logic [15:0]        fade_ms;
    logic               in_rdy;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               out_rdy;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic [8:0]         gain;
    logic               fading;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    logic               got_rdy;
    logic signed [15:0] got_l;
    logic signed [15:0] got_r;
    logic [8:0]         got_gain;
    logic               got_fading;
    logic               got_done;

    audio_fader #(.SAMPLE_RATE(100)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .length_s (length_s),
        .fade_ms  (fade_ms),
        .in_rdy   (in_rdy),
        .in_l     (in_l),
        .in_r     (in_r),
        .out_rdy  (out_rdy),
        .out_l    (out_l),
        .out_r    (out_r),
        .gain     (gain),
        .fading   (fading),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One input strobe; snapshot outputs in the out_rdy cycle, then gap 3 cycles.
    task automatic send(input logic signed [15:0] l, input logic signed [15:0] r,
                        input logic st, input logic ab);
        in_rdy = 1'b1;
        in_l   = l;
        in_r   = r;
        start  = st;
        abort  = ab;
        @(posedge clk);
        #1;
        in_rdy     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        got_rdy    = out_rdy;
        got_l      = out_l;
        got_r      = out_r;
        got_gain   = gain;
        got_fading = fading;
        got_done   = done;
        idle(3);
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] fms);
        length_s = len;
        fade_ms  = fms;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(1);
    endtask

    initial begin
        int g;
        int e_l;
        int e_r;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        length_s = 16'd0;
        fade_ms  = 16'd0;
        in_rdy   = 1'b0;
        in_l     = 16'sd0;
        in_r     = 16'sd0;
        idle(2);
        check("reset_gain", 32'(gain), 32'd0);
        check("reset_out_l", 32'(out_l), 32'd0);
        check("reset_out_rdy", 32'(out_rdy), 32'd0);
        check("reset_fading", 32'(fading), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        idle(1);

        // Idle: output is muted.
        send(16'sh1234, 16'sh1234, 1'b0, 1'b0);
        check("idle_rdy", 32'(got_rdy), 32'd1);
        check("idle_out_l", 32'(got_l), 32'd0);
        check("idle_gain", 32'(got_gain), 32'd0);
        check("idle_done", 32'(got_done), 32'd0);
        check("rdy_low_after", 32'(out_rdy), 32'd0);

`ifdef AUDIO_FADER_SOFTSTART_EN
        // Soft start: constant 256 input ramps 0,1,...,256 then holds.
        do_start(16'd0, 16'd80);
        check("ss_gain0", 32'(gain), 32'd0);
        for (int i = 0; i < 262; i++) begin
            send(16'sd256, 16'sd256, 1'b0, 1'b0);
            check("ss_out_l", 32'(got_l), 32'((i > 256) ? 256 : i));
            check("ss_out_r", 32'(got_r), 32'((i > 256) ? 256 : i));
        end
        check("ss_gain_final", 32'(gain), 32'd256);
`else
        // Play 2 s at 100 samples/s, then 80 ms fade (10 samples per step).
        do_start(16'd2, 16'd80);
        check("play_gain", 32'(gain), 32'd256);
        check("play_fading", 32'(fading), 32'd0);
        for (int i = 1; i <= 200; i++) begin
            send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
            check("play_out_l", 32'(got_l), -32'sd1000);
            check("play_out_r", 32'(got_r), 32'd1000);
            if (i == 199) check("pre_fade_fading", 32'(got_fading), 32'd0);
        end
        check("fade_entry_fading", 32'(got_fading), 32'd1);
        check("fade_entry_gain", 32'(got_gain), 32'd256);
        g = 256;
        for (int k = 1; k <= 2560; k++) begin
            send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
            e_l = (-1000 * g) >>> 8;
            e_r = (1000 * g) >>> 8;
            check("fade_out_l", 32'(got_l), 32'(e_l));
            check("fade_out_r", 32'(got_r), 32'(e_r));
            if ((k % 10) == 0) g--;
            check("fade_gain", 32'(got_gain), 32'(g));
            check("fade_done", 32'(got_done), 32'(k == 2560));
            check("fade_fading", 32'(got_fading), 32'(k != 2560));
        end
        check("done_pulse_len", 32'(done), 32'd0);
        send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
        check("after_done_out_l", 32'(got_l), 32'd0);
        check("after_done_gain", 32'(got_gain), 32'd0);
        check("after_done_done", 32'(got_done), 32'd0);

        // Arithmetic corners: 1 s play then 1 sample per step.
        do_start(16'd1, 16'd8);
        for (int i = 0; i < 228; i++) send(16'sd0, 16'sd0, 1'b0, 1'b0);
        send(16'sh7FFF, 16'sh8000, 1'b0, 1'b0);
        check("g128_pos", 32'(got_l), 32'h0000_3FFF);
        check("g128_neg", 32'(got_r), 32'hFFFF_C000);
        for (int i = 0; i < 126; i++) send(16'sd0, 16'sd0, 1'b0, 1'b0);
        check("g1_gain_before", 32'(got_gain), 32'd1);
        send(16'sh8000, 16'sh7FFF, 1'b0, 1'b0);
        check("g1_neg", 32'(got_l), 32'hFFFF_FF80);
        check("g1_pos", 32'(got_r), 32'd127);
        check("g1_done", 32'(got_done), 32'd1);

        // Zero fade time goes straight to DONE.
        do_start(16'd2, 16'd0);
        for (int i = 1; i < 200; i++) begin
            send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
            if (i == 199) check("nofade_pre_out", 32'(got_l), -32'sd1000);
        end
        send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
        check("nofade_out", 32'(got_l), -32'sd1000);
        check("nofade_done", 32'(got_done), 32'd1);
        check("nofade_fading", 32'(got_fading), 32'd0);
        check("nofade_gain", 32'(got_gain), 32'd0);
        send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
        check("nofade_after_out", 32'(got_l), 32'd0);
        check("nofade_after_done", 32'(got_done), 32'd0);

        // Abort mid-fade, then restart coincident with a sample.
        do_start(16'd1, 16'd80);
        for (int i = 0; i < 125; i++) send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
        check("midfade_gain", 32'(got_gain), 32'd254);
        check("midfade_fading", 32'(got_fading), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_gain", 32'(gain), 32'd0);
        check("abort_fading", 32'(fading), 32'd0);
        idle(2);
        send(-16'sd1000, 16'sd1000, 1'b1, 1'b0);
        check("start_coinc_out", 32'(got_l), 32'd0);
        check("start_coinc_gain", 32'(got_gain), 32'd256);
        for (int i = 0; i < 3; i++) begin
            send(-16'sd1000, 16'sd1000, 1'b0, 1'b0);
            check("restart_out_l", 32'(got_l), -32'sd1000);
            check("restart_out_r", 32'(got_r), 32'd1000);
        end
        send(-16'sd1000, 16'sd1000, 1'b0, 1'b1);
        check("abort_coinc_out", 32'(got_l), 32'd0);
        check("abort_coinc_gain", 32'(got_gain), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
